// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stage registers
package pipe_pkg;
  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam int CTRL_W = 5;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_BRANCH = 4;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one held entry (valid, ctrl, payload) with load, drop and flush-clear
module pipe_entry #(
  parameter int PAYLOAD_W = 133,
  parameter int CTRL_W = 5,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 ld_i,
  input  logic                 drop_i,
  input  logic [CTRL_W-1:0]    ctrl_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [PAYLOAD_W-1:0] payload_o
);
  logic                 valid_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [PAYLOAD_W-1:0] payload_q;
  // ctrl is zeroed whenever the entry goes invalid so bubbles never carry control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q <= '0;
      payload_q <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q <= '0;
      if (CLEAR_PAYLOAD) payload_q <= '0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      ctrl_q <= ctrl_i;
      payload_q <= payload_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
      ctrl_q <= '0;
    end
  end
  assign valid_o = valid_q;
  assign ctrl_o = ctrl_q;
  assign payload_o = payload_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with registered ready, 2-entry skid and flush
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 133,
  parameter int CTRL_W = 5,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [CTRL_W-1:0]    in_ctrl_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [CTRL_W-1:0]    out_ctrl_o,
  output logic [1:0]           occupancy_o
);
  import pipe_pkg::*;
  state_e state_q, state_d;
  logic in_fire, out_fire, m_ld, m_drop, s_ld, s_drop, s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [PAYLOAD_W-1:0] s_payload;
  assign in_ready_o = state_q != FULL;
  assign occupancy_o = state_q;
  assign in_fire = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;
  always_comb begin
    state_d = state_q;
    m_ld = 1'b0;
    m_drop = 1'b0;
    s_ld = 1'b0;
    s_drop = 1'b0;
    if (flush_i) state_d = EMPTY;
    else case (state_q)
      EMPTY: begin
        m_ld = in_fire;
        state_d = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        m_ld = in_fire & out_fire;
        s_ld = in_fire & ~out_fire;
        m_drop = out_fire & ~in_fire;
        state_d = s_ld ? FULL : m_drop ? EMPTY : ONE;
      end
      FULL: begin
        m_ld = out_fire;
        s_drop = out_fire;
        state_d = out_fire ? ONE : FULL;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // skid is valid only in FULL, so it selects the refill source for main
  pipe_entry #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W), .CLEAR_PAYLOAD(CLEAR_PAYLOAD)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .ld_i(m_ld), .drop_i(m_drop),
    .ctrl_i(s_valid ? s_ctrl : in_ctrl_i), .payload_i(s_valid ? s_payload : in_payload_i),
    .valid_o(out_valid_o), .ctrl_o(out_ctrl_o), .payload_o(out_payload_o)
  );
  pipe_entry #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W), .CLEAR_PAYLOAD(CLEAR_PAYLOAD)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(flush_i), .ld_i(s_ld), .drop_i(s_drop),
    .ctrl_i(in_ctrl_i), .payload_i(in_payload_i),
    .valid_o(s_valid), .ctrl_o(s_ctrl), .payload_o(s_payload)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random and directed stimulus checked against a capacity-2 FIFO model
module tb_pipe_stage_skid;
  typedef struct {logic [132:0] p; logic [4:0] c;} ent_t;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [132:0] in_payload;
  logic [4:0] in_ctrl;
  logic a_in_ready, a_out_valid, z_in_ready, z_out_valid;
  logic [132:0] a_payload, z_payload;
  logic [4:0] a_ctrl, z_ctrl;
  logic [1:0] a_occ, z_occ;
  int tests = 0, fails = 0;
  ent_t q[$];
  logic [132:0] held = '0, held0 = '0;
  always #5 clk = ~clk;
  pipe_stage_skid #(.CLEAR_PAYLOAD(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_payload_i(in_payload), .in_ctrl_i(in_ctrl), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_payload_o(a_payload), .out_ctrl_o(a_ctrl), .occupancy_o(a_occ));
  pipe_stage_skid #(.CLEAR_PAYLOAD(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(z_in_ready),
    .in_payload_i(in_payload), .in_ctrl_i(in_ctrl), .out_valid_o(z_out_valid), .out_ready_i(out_ready),
    .out_payload_o(z_payload), .out_ctrl_o(z_ctrl), .occupancy_o(z_occ));
  task automatic chk(input string n, input logic [132:0] act, input logic [132:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  // compare every cycle, then advance the model by the handshake the next edge will see
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("occupancy", 133'(a_occ), 133'(n));
    chk("in_ready", 133'(a_in_ready), 133'(n < 2));
    chk("out_valid", 133'(a_out_valid), 133'(n > 0));
    chk("out_ctrl", 133'(a_ctrl), n > 0 ? 133'(q[0].c) : '0);
    chk("out_payload", a_payload, n > 0 ? q[0].p : held);
    chk("nc_occupancy", 133'(z_occ), 133'(n));
    chk("nc_in_ready", 133'(z_in_ready), 133'(n < 2));
    chk("nc_out_valid", 133'(z_out_valid), 133'(n > 0));
    chk("nc_out_ctrl", 133'(z_ctrl), n > 0 ? 133'(q[0].c) : '0);
    chk("nc_out_payload", z_payload, n > 0 ? q[0].p : held0);
    if (rst) begin
      q.delete();
      held = '0;
      held0 = '0;
    end else if (flush) begin
      q.delete();
      held = '0;
    end else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (n < 2 && in_valid) q.push_back('{p: in_payload, c: in_ctrl});
    end
    if (q.size() > 0) begin
      held = q[0].p;
      held0 = q[0].p;
    end
  end
  task automatic cyc(input logic v, input logic [132:0] p, input logic [4:0] c,
                     input logic ordy, input logic fl, input logic r);
    in_valid = v;
    in_payload = p;
    in_ctrl = c;
    out_ready = ordy;
    flush = fl;
    rst = r;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [132:0] rnd_p();
    return {5'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_payload = '0; in_ctrl = '0;
    repeat (2) cyc(1'b1, rnd_p(), 5'h1f, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 133'(i), 5'($urandom), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 133'hA, 5'h01, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 133'hB, 5'h02, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 133'hC, 5'h04, 1'b0, 1'b0, 1'b0);
    chk("stall_in_ready", 133'(a_in_ready), '0);
    cyc(1'b1, 133'hC, 5'h04, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 133'hC, 5'h04, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 133'h111, 5'h1f, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 133'h222, 5'h1f, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 133'h333, 5'h1f, 1'b0, 1'b1, 1'b0);
    chk("flush_payload", a_payload, '0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 133'hDEAD, 5'h03, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("noclear_hold", z_payload, 133'hDEAD);
    chk("noclear_ctrl", 133'(z_ctrl), '0);
    repeat (3) cyc(1'b0, rnd_p(), 5'h01, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, rnd_p(), 5'h1f, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd_p(), 5'h1f, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd_p(), 5'h1f, 1'b0, 1'b1, 1'b1);
    chk("rst_full_valid", 133'(a_out_valid), '0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_full_ready", 133'(a_in_ready), 133'(1));
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, rnd_p(), 5'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
